// File: rtl/multi_cycle_alu.sv
// multi_cycle_alu: 16-bit ADD/SUB/MUL/DIV unit with a level request handshake.
//
// Ports:
//   Clock       in   rising-edge clock for all state
//   Reset       in   synchronous, active-high reset
//   ALUOP[1:0]  in   00 ADD, 01 SUB, 10 MUL, 11 DIV (signed, truncating)
//   ALU_A[15:0] in   operand A / dividend
//   ALU_B[15:0] in   operand B / divisor
//   ALU_Start   in   request level, held high until ALU_Done is seen
//   ALU_Result  out  registered result, held until the next completed operation
//   ALU_Done    out  registered one-cycle completion pulse
//   ALU_Busy    out  registered, high while in RUN or DONE
//
// ADD/SUB take one RUN cycle. MUL and DIV take 16 RUN cycles (one bit per
// cycle). HOLD absorbs a request still held high after Done, so it is
// never taken as a second operation.

module multi_cycle_alu (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  ALUOP,
  input  logic [15:0] ALU_A,
  input  logic [15:0] ALU_B,
  input  logic        ALU_Start,
  output logic [15:0] ALU_Result,
  output logic        ALU_Done,
  output logic        ALU_Busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  // MUL: a = shifted multiplicand, b = shifted multiplier, acc = partial sum.
  // DIV: a = dividend magnitude shifting into quotient, b = divisor
  //      magnitude, acc = partial remainder.
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          dz_q, dz_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  // Combinational helpers for the datapath.
  logic [DW:0]   rem_shift;
  logic          take_sub;
  logic [DW-1:0] quot;
  logic [DW-1:0] quot_signed;
  logic [DW-1:0] mul_sum;

  // State and datapath registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, datapath iteration and registered-output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    result_d    = result_q;

    // Restoring-divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits.
    rem_shift   = {acc_q, a_q[DW-1]};
    take_sub    = (rem_shift >= {1'b0, b_q});
    quot        = {a_q[DW-2:0], take_sub};
    quot_signed = neg_q ? DW'(-quot) : quot;

    // Shift-add step: only the low 16 bits of the product are kept, which
    // are the same for signed and unsigned operands.
    mul_sum     = acc_q + (b_q[0] ? a_q : '0);

    case (state_q)
      S_IDLE: begin
        if (ALU_Start) begin
          op_d  = ALUOP;
          cnt_d = '0;
          acc_d = '0;
          if (ALUOP == OP_DIV) begin
            // 16'h8000 has no positive counterpart but its unsigned
            // magnitude is still 16'h8000, so the divide stays correct.
            a_d   = ALU_A[DW-1] ? DW'(-ALU_A) : ALU_A;
            b_d   = ALU_B[DW-1] ? DW'(-ALU_B) : ALU_B;
            neg_d = ALU_A[DW-1] ^ ALU_B[DW-1];
            dz_d  = (ALU_B == '0);
          end else begin
            a_d   = ALU_A;
            b_d   = ALU_B;
            neg_d = 1'b0;
            dz_d  = 1'b0;
          end
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        case (op_q)
          OP_ADD: begin
            result_d = a_q + b_q;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = a_q - b_q;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            acc_d = mul_sum;
            a_d   = {a_q[DW-2:0], 1'b0};
            b_d   = {1'b0, b_q[DW-1:1]};
            if (cnt_q == LAST_ITER) begin
              result_d = mul_sum;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          OP_DIV: begin
            acc_d = take_sub ? DW'(rem_shift - {1'b0, b_q}) : rem_shift[DW-1:0];
            a_d   = quot;
            if (cnt_q == LAST_ITER) begin
              // Divide by zero still runs all iterations; result is forced.
              result_d = dz_q ? {DW{1'b1}} : quot_signed;
              state_d  = S_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        endcase
      end

      S_DONE: begin
        state_d = ALU_Start ? S_HOLD : S_IDLE;
      end

      S_HOLD: begin
        if (!ALU_Start) begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Outputs are registered so they line up with the state they describe.
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_RUN) || (state_d == S_DONE);
  end

  assign ALU_Result = result_q;
  assign ALU_Done   = done_q;
  assign ALU_Busy   = busy_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed testbench for multi_cycle_alu. Cycle n after an accept edge is
// observed at the n-th falling edge following that accept edge.

module tb_multi_cycle_alu;

  logic        clk;
  logic        rst;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        start;
  logic [15:0] result;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  multi_cycle_alu dut (
    .Clock     (clk),
    .Reset     (rst),
    .ALUOP     (op),
    .ALU_A     (a),
    .ALU_B     (b),
    .ALU_Start (start),
    .ALU_Result(result),
    .ALU_Done  (done),
    .ALU_Busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, wait for Done, then release the request after
  // 'hold' extra cycles. With 'corrupt' set, inputs are scrambled during RUN.
  task automatic do_op(input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] exp_r,
                       input int exp_lat, input int hold, input bit corrupt,
                       input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_in_run: got %b want 1", nm, busy);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = n;
      end else if (corrupt) begin
        op = 2'($urandom);
        a  = 16'($urandom);
        b  = 16'($urandom);
      end
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", nm, lat, seen, exp_lat);
    end
    checks++;
    if (result !== exp_r) begin
      failures++;
      $display("FAIL %s result: got %h want %h", nm, result, exp_r);
    end
    // Dropping the request during DONE must not shorten the pulse.
    if (hold == 0) start = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s hold_%0d: done=%b busy=%b want 0 0", nm, h, done, busy);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b want 0 0", nm, done, busy);
    end
    checks++;
    if (result !== exp_r) begin
      failures++;
      $display("FAIL %s result_held: got %h want %h", nm, result, exp_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0001;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: result=%h done=%b busy=%b want 0000 0 0", result, done, busy);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_idle();
    op = 2'b10; a = 16'h1234; b = 16'h0002; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
        failures++;
        $display("FAIL idle_%0d: done=%b busy=%b result=%h want 0 0 0000", i, done, busy, result);
      end
    end
  endtask

  task automatic test_addsub();
    do_op(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 2, 0, 1'b0, "add_wrap");
    do_op(2'b01, 16'd3, 16'd5, 16'hFFFE, 2, 0, 1'b0, "sub_neg");
  endtask

  task automatic test_mul();
    do_op(2'b10, 16'd300, 16'd300, 16'h5F90, 17, 0, 1'b0, "mul_300x300");
    do_op(2'b10, 16'hFFFD, 16'd7, 16'hFFEB, 17, 0, 1'b0, "mul_neg3x7");
  endtask

  task automatic test_div();
    do_op(2'b11, 16'hFFF9, 16'd2, 16'hFFFD, 17, 0, 1'b0, "div_m7_2");
    do_op(2'b11, 16'd7, 16'hFFFE, 16'hFFFD, 17, 0, 1'b0, "div_7_m2");
    do_op(2'b11, 16'd100, 16'd0, 16'hFFFF, 17, 0, 1'b0, "div_by_zero");
    do_op(2'b11, 16'h8000, 16'hFFFF, 16'h8000, 17, 0, 1'b0, "div_min_m1");
  endtask

  task automatic test_handshake();
    do_op(2'b00, 16'd1, 16'd2, 16'h0003, 2, 5, 1'b0, "hs_hold");
    do_op(2'b01, 16'd10, 16'd4, 16'h0006, 2, 0, 1'b0, "hs_reaccept");
  endtask

  task automatic test_corrupt();
    do_op(2'b10, 16'd12, 16'd12, 16'd144, 17, 0, 1'b1, "mul_corrupt");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = 2'b11; a = 16'd1000; b = 16'd7; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_run: done=%b busy=%b result=%h want 0 0 0000", done, busy, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet_%0d: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    do_op(2'b00, 16'd2, 16'd2, 16'h0004, 2, 0, 1'b0, "after_reset_add");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    test_reset();
    test_idle();
    test_addsub();
    test_mul();
    test_div();
    test_handshake();
    test_corrupt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
